// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the LC-3b memory controller: FSM state encodings,
// access size codes and default latency (also used by the datapath control store).
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int DEFAULT_LATENCY = 5;
    localparam int CNT_W           = 4;

    // The accept edge and the DONE edge bracket the countdown, hence the -2.
    function automatic logic [CNT_W-1:0] cnt_load(input int latency);
        return CNT_W'(latency - 2);
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering for the memory controller: write-data placement,
// per-lane write enables and read-word assembly. Purely combinational.
module mem_lane_steer
    import mem_ctrl_pkg::*;
(
    input  logic        size,
    input  logic        mar0,
    input  logic        r_w,
    input  logic [15:0] mdr,
    input  logic [7:0]  lo_rdata,
    input  logic [7:0]  hi_rdata,
    output logic [7:0]  lo_wdata,
    output logic [7:0]  hi_wdata,
    output logic        lo_we,
    output logic        hi_we,
    output logic [15:0] rdata
);

    // Byte writes replicate the low byte so either lane can take it;
    // byte reads select the lane by mar[0] and zero-extend.
    always_comb begin
        lo_wdata = mdr[7:0];
        hi_wdata = mdr[7:0];
        lo_we    = 1'b0;
        hi_we    = 1'b0;
        rdata    = 16'h0000;
        if (size == SIZE_WORD) begin
            hi_wdata = mdr[15:8];
            lo_we    = r_w;
            hi_we    = r_w;
            rdata    = {hi_rdata, lo_rdata};
        end else begin
            lo_we    = r_w & ~mar0;
            hi_we    = r_w &  mar0;
            rdata    = {8'h00, (mar0 ? hi_rdata : lo_rdata)};
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// LC-3b memory interface controller. Accepts a word/byte request in IDLE,
// drives two 8-bit byte lanes for a fixed LATENCY and pulses ready on
// completion. Optional macro MEM_CTRL_BOUNDS_EN flags requests whose
// mar[15:9] is nonzero (err with ready, no strobe, no read capture);
// without it those bits are ignored and addresses alias.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int LANE_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mio_en,
    input  logic               r_w,
    input  logic               data_size,
    input  logic [15:0]        mar,
    input  logic [15:0]        mdr_in,
    output logic [15:0]        mem_rdata,
    output logic               ready,
    output logic               err,
    output logic [LANE_AW-1:0] lo_addr,
    output logic [LANE_AW-1:0] hi_addr,
    output logic [7:0]         lo_wdata,
    output logic [7:0]         hi_wdata,
    output logic               lo_write_n,
    output logic               hi_write_n,
    input  logic [7:0]         lo_rdata,
    input  logic [7:0]         hi_rdata
);

    localparam logic [CNT_W-1:0] CNT_INIT = cnt_load(LATENCY);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             accept, finish;

    logic             rw_q, size_q, mar0_q, oob_q;
    logic             req_oob;

    logic             sel_size, sel_mar0;
    logic [7:0]       st_lo_wdata, st_hi_wdata;
    logic             st_lo_we, st_hi_we;
    logic [15:0]      st_rdata;

`ifdef MEM_CTRL_BOUNDS_EN
    assign req_oob = |mar[15:LANE_AW+1];
`else
    logic unused_mar_hi;
    assign req_oob       = 1'b0;
    assign unused_mar_hi = ^mar[15:LANE_AW+1];
`endif

    // In IDLE the steering sees the live request; afterwards the captured one.
    assign sel_size = (state == IDLE) ? data_size : size_q;
    assign sel_mar0 = (state == IDLE) ? mar[0]    : mar0_q;

    mem_lane_steer u_steer (
        .size     (sel_size),
        .mar0     (sel_mar0),
        .r_w      (r_w),
        .mdr      (mdr_in),
        .lo_rdata (lo_rdata),
        .hi_rdata (hi_rdata),
        .lo_wdata (st_lo_wdata),
        .hi_wdata (st_hi_wdata),
        .lo_we    (st_lo_we),
        .hi_we    (st_hi_we),
        .rdata    (st_rdata)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic with accept/finish qualifiers
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (mio_en) begin
                next_state = WAIT;
                accept     = 1'b1;
            end
            WAIT: if (cnt == '0) begin
                next_state = DONE;
                finish     = 1'b1;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latency countdown, loaded on accept and run down through WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         cnt <= '0;
        else if (accept)                    cnt <= CNT_INIT;
        else if (state == WAIT && cnt != 0) cnt <= cnt - 1'b1;
    end

    // Request capture, lane outputs, one-cycle strobes, ready and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            mar0_q     <= 1'b0;
            oob_q      <= 1'b0;
            lo_addr    <= '0;
            hi_addr    <= '0;
            lo_wdata   <= 8'h00;
            hi_wdata   <= 8'h00;
            lo_write_n <= 1'b1;
            hi_write_n <= 1'b1;
            ready      <= 1'b0;
            mem_rdata  <= 16'h0000;
        end else begin
            lo_write_n <= ~(accept & st_lo_we & ~req_oob);
            hi_write_n <= ~(accept & st_hi_we & ~req_oob);
            ready      <= finish;
            if (accept) begin
                rw_q     <= r_w;
                size_q   <= data_size;
                mar0_q   <= mar[0];
                oob_q    <= req_oob;
                lo_addr  <= mar[LANE_AW:1];
                hi_addr  <= mar[LANE_AW:1];
                lo_wdata <= st_lo_wdata;
                hi_wdata <= st_hi_wdata;
            end
            if (finish && !rw_q && !oob_q)
                mem_rdata <= st_rdata;
        end
    end

`ifdef MEM_CTRL_BOUNDS_EN
    // Out-of-range flag, coincident with the ready pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err <= 1'b0;
        else        err <= finish & oob_q;
    end
`else
    assign err = 1'b0;
`endif

endmodule
